// File: rtl/mem_req_arbiter_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory-request arbiter.
//   arb_state_e : 2-bit sequencer state (IDLE / ISSUE / WAIT_DONE / DONE)
//   rr_next     : round-robin successor of an index, wrapping at n, so a
//                 non-power-of-two requester count never lands on a hole.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_DONE = 2'd2,
    ARB_DONE      = 2'd3
  } arb_state_e;

  function automatic int rr_next(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// mem_req_arbiter_if: request/splitter bus around the memory-request arbiter.
//   Requester side : req_valid/req_addr/req_size in, req_ready/req_done out
//                    (packed, requester i at slice i).
//   Splitter side  : spl_idle in, spl_addr/spl_addr_valid/spl_size out.
// Modports are named from the requesters' point of view: "slave" is the
// arbiter itself, "master" is the environment (requesters plus splitter).
interface mem_req_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int REQ_SIZE_WIDTH = 16
) ();

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr;
  logic [NUM_REQ*REQ_SIZE_WIDTH-1:0] req_size;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0]                req_done;

  logic                              spl_idle;
  logic [ADDR_WIDTH-1:0]             spl_addr;
  logic                              spl_addr_valid;
  logic [REQ_SIZE_WIDTH-1:0]         spl_size;

  modport slave (
    input  req_valid, req_addr, req_size, spl_idle,
    output req_ready, req_done, spl_addr, spl_addr_valid, spl_size
  );

  modport master (
    output req_valid, req_addr, req_size, spl_idle,
    input  req_ready, req_done, spl_addr, spl_addr_valid, spl_size
  );

endinterface

// File: rtl/mem_req_arbiter_picker.sv
// rr_priority_picker: purely combinational round-robin pick.
//   req : request vector
//   ptr : index with highest priority this cycle (must be < N)
//   gnt : one-hot winner, idx : its index, any : some request present
// Scan order is ptr, ptr+1, ..., wrapping at N.
module rr_priority_picker #(
  parameter  int N   = 4,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[IDW'(j)]) begin
        any           = 1'b1;
        gnt[IDW'(j)]  = 1'b1;
        idx           = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin arbiter/sequencer sharing one memory-request
// splitter among NUM_REQ requesters.
//   clk, reset          : clock, synchronous active-high reset
//   bus (slave)         : requester handshake + splitter request channel
//   txn_done            : pulse, granted transaction fully answered
//   grant_id            : current owner (meaningful while busy)
//   busy                : sequencer not idle
//   err_unexpected_done : sticky, txn_done arrived while not waiting for it
// Flow: IDLE picks a winner and latches its address/size, ISSUE strobes the
// splitter for one cycle, WAIT_DONE holds the grant until txn_done, DONE
// pulses req_done and advances the round-robin pointer past the owner.
// A zero-size request skips ISSUE/WAIT_DONE and completes directly.
module mem_req_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int ADDR_WIDTH     = 64,
  parameter  int REQ_SIZE_WIDTH = 16,
  localparam int ID_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  mem_req_arbiter_if.slave    bus,
  input  logic                txn_done,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                busy,
  output logic                err_unexpected_done
);

  import mem_arb_pkg::*;

  arb_state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]       grant_id_q, grant_id_d;
  logic [ADDR_WIDTH-1:0]     spl_addr_q, spl_addr_d;
  logic [REQ_SIZE_WIDTH-1:0] spl_size_q, spl_size_d;
  logic                      err_q, err_d;

  logic [NUM_REQ-1:0]        pick_gnt;
  logic [ID_WIDTH-1:0]       pick_idx;
  logic                      pick_any;
  logic                      grant_now;
  logic [ADDR_WIDTH-1:0]     win_addr;
  logic [REQ_SIZE_WIDTH-1:0] win_size;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // A grant needs an idle sequencer and a splitter able to take a request.
  assign grant_now = (state_q == ARB_IDLE) && bus.spl_idle && pick_any;

  always_comb begin
    win_addr = '0;
    win_size = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == ID_WIDTH'(i)) begin
        win_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        win_size = bus.req_size[i*REQ_SIZE_WIDTH +: REQ_SIZE_WIDTH];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      spl_addr_q <= '0;
      spl_size_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      spl_addr_q <= spl_addr_d;
      spl_size_q <= spl_size_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    spl_addr_d = spl_addr_q;
    spl_size_d = spl_size_q;
    // txn_done only belongs in WAIT_DONE; anywhere else it is a protocol error.
    err_d      = err_q | (txn_done && (state_q != ARB_WAIT_DONE));
    case (state_q)
      ARB_IDLE: begin
        if (grant_now) begin
          grant_id_d = pick_idx;
          spl_addr_d = win_addr;
          spl_size_d = win_size;
          state_d    = (win_size == '0) ? ARB_DONE : ARB_ISSUE;
        end
      end
      ARB_ISSUE:     state_d = ARB_WAIT_DONE;
      ARB_WAIT_DONE: if (txn_done) state_d = ARB_DONE;
      ARB_DONE: begin
        rr_ptr_d = ID_WIDTH'(rr_next(int'(grant_id_q), NUM_REQ));
        state_d  = ARB_IDLE;
      end
      default:       state_d = ARB_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.req_ready      = '0;
    bus.req_done       = '0;
    bus.spl_addr_valid = (state_q == ARB_ISSUE);
    if (grant_now) bus.req_ready = pick_gnt;
    if (state_q == ARB_DONE) bus.req_done[grant_id_q] = 1'b1;
  end

  assign bus.spl_addr        = spl_addr_q;
  assign bus.spl_size        = spl_size_q;
  assign grant_id            = grant_id_q;
  assign busy                = (state_q != ARB_IDLE);
  assign err_unexpected_done = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: a 4-requester instance checked every cycle
// against a transaction-level model, plus a 3-requester instance exercising
// pointer wrap with literal expectations.
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.NUM_REQ(4), .ADDR_WIDTH(64), .REQ_SIZE_WIDTH(16)) bus4 ();
  mem_req_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(64), .REQ_SIZE_WIDTH(16)) bus3 ();

  logic       txn4 = 1'b0, txn3 = 1'b0;
  logic [1:0] gid4, gid3;
  logic       busy4, busy3, err4, err3;

  mem_req_arbiter #(.NUM_REQ(4), .ADDR_WIDTH(64), .REQ_SIZE_WIDTH(16)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .txn_done(txn4),
    .grant_id(gid4), .busy(busy4), .err_unexpected_done(err4));

  mem_req_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(64), .REQ_SIZE_WIDTH(16)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .txn_done(txn3),
    .grant_id(gid3), .busy(busy3), .err_unexpected_done(err3));

  int n_checks = 0;
  int n_errors = 0;
  bit auto_clear = 1'b1;
  logic [3:0] rdy4_seen = '0;
  logic [2:0] rdy3_seen = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requesters drop valid once accepted (when auto_clear is set).
  always @(negedge clk) begin
    rdy4_seen = bus4.req_ready;
    rdy3_seen = bus3.req_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_clear) begin
      bus4.req_valid = bus4.req_valid & ~rdy4_seen;
      bus3.req_valid = bus3.req_valid & ~rdy3_seen;
    end
  endtask

  task automatic set_req4(input int i, input logic [63:0] a, input logic [15:0] s);
    bus4.req_addr[i*64 +: 64] = a;
    bus4.req_size[i*16 +: 16] = s;
    bus4.req_valid[i] = 1'b1;
  endtask

  task automatic set_req3(input int i, input logic [63:0] a, input logic [15:0] s);
    bus3.req_addr[i*64 +: 64] = a;
    bus3.req_size[i*16 +: 16] = s;
    bus3.req_valid[i] = 1'b1;
  endtask

  task automatic wait_ready4(input int max, output logic [3:0] oh);
    oh = '0;
    for (int c = 0; c < max; c++) begin
      #1;
      if (|bus4.req_ready) begin
        oh = bus4.req_ready;
        return;
      end
      tick();
    end
  endtask

  // After the accepting edge: ISSUE, WAIT_DONE, txn_done, DONE, back to IDLE.
  task automatic finish4();
    tick();
    tick();
    txn4 = 1'b1;
    tick();
    txn4 = 1'b0;
    tick();
  endtask

  // ---------------------------------------------------------------------
  // Reference model for the 4-requester instance. It tracks one owner and
  // three pending obligations (strobe due, completion outstanding, done
  // pulse due); arbitration scans (ptr+k) mod 4.
  // ---------------------------------------------------------------------
  int          m_owner = -1;
  int          m_ptr = 0;
  bit          m_strobe = 0, m_out = 0, m_fin = 0, m_err = 0, m_known = 0;
  logic [1:0]  m_id = '0;
  logic [63:0] m_addr = '0;
  logic [15:0] m_size = '0;

  always @(negedge clk) begin : model
    int w;
    int j;
    logic [3:0] e_rdy;
    logic [3:0] e_done;
    w = -1;
    if (m_owner < 0 && bus4.spl_idle === 1'b1) begin
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (w < 0 && bus4.req_valid[j[1:0]]) w = j;
      end
    end
    e_rdy  = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    e_done = m_fin ? (4'b0001 << m_owner) : 4'b0000;
    if (m_known) begin
      chk("m_req_ready", 64'(bus4.req_ready), 64'(e_rdy));
      chk("m_req_done", 64'(bus4.req_done), 64'(e_done));
      chk("m_spl_addr_valid", 64'(bus4.spl_addr_valid), 64'(m_strobe));
      chk("m_busy", 64'(busy4), 64'(m_owner >= 0));
      chk("m_err", 64'(err4), 64'(m_err));
      chk("m_spl_addr", bus4.spl_addr, m_addr);
      chk("m_spl_size", 64'(bus4.spl_size), 64'(m_size));
      if (m_owner >= 0) chk("m_grant_id", 64'(gid4), 64'(m_id));
    end
    if (reset) begin
      m_owner = -1; m_ptr = 0; m_strobe = 0; m_out = 0; m_fin = 0; m_err = 0;
      m_id = '0; m_addr = '0; m_size = '0; m_known = 1;
    end else if (m_known) begin
      if (txn4 && !m_out) m_err = 1;
      if (m_owner < 0) begin
        if (w >= 0) begin
          m_owner = w;
          m_id    = w[1:0];
          m_addr  = bus4.req_addr[w*64 +: 64];
          m_size  = bus4.req_size[w*16 +: 16];
          if (m_size != 0) m_strobe = 1; else m_fin = 1;
        end
      end else if (m_strobe) begin
        m_strobe = 0;
        m_out    = 1;
      end else if (m_out) begin
        if (txn4) begin m_out = 0; m_fin = 1; end
      end else if (m_fin) begin
        m_fin   = 0;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] oh;
    logic [3:0] exp_order [5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    bus4.req_valid = '0; bus4.req_addr = '0; bus4.req_size = '0; bus4.spl_idle = 1'b1;
    bus3.req_valid = '0; bus3.req_addr = '0; bus3.req_size = '0; bus3.spl_idle = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", 64'(busy4), 64'd0);
    chk("rst_ready", 64'(bus4.req_ready), 64'd0);
    chk("rst_spl_addr", bus4.spl_addr, 64'd0);
    chk("rst_grant_id", 64'(gid4), 64'd0);
    chk("rst_err", 64'(err4), 64'd0);

    // 1: single request, requester 2
    tick();
    set_req4(2, 64'h1040, 16'd256);
    #1;
    chk("t1_ready_same_cycle", 64'(bus4.req_ready), 64'b0100);
    tick();
    chk("t1_strobe", 64'(bus4.spl_addr_valid), 64'd1);
    chk("t1_addr", bus4.spl_addr, 64'h1040);
    chk("t1_size", 64'(bus4.spl_size), 64'd256);
    chk("t1_gid", 64'(gid4), 64'd2);
    tick();
    chk("t1_strobe_once", 64'(bus4.spl_addr_valid), 64'd0);
    repeat (9) tick();
    txn4 = 1'b1;
    tick();
    txn4 = 1'b0;
    #1;
    chk("t1_done", 64'(bus4.req_done), 64'b0100);
    tick();
    chk("t1_idle_busy", 64'(busy4), 64'd0);
    chk("t1_done_pulse", 64'(bus4.req_done), 64'd0);
    chk("t1_addr_hold", bus4.spl_addr, 64'h1040);

    // 3: NUM_REQ=3 instance, grant 2 then wrap to 0 ahead of 1
    set_req3(2, 64'h3000, 16'd4);
    #1;
    chk("t3_ready2", 64'(bus3.req_ready), 64'b100);
    tick();
    tick();
    txn3 = 1'b1;
    tick();
    txn3 = 1'b0;
    #1;
    chk("t3_done2", 64'(bus3.req_done), 64'b100);
    set_req3(0, 64'h3100, 16'd8);
    set_req3(1, 64'h3200, 16'd8);
    tick();
    chk("t3_wrap_ready0", 64'(bus3.req_ready), 64'b001);
    tick();
    chk("t3_gid0", 64'(gid3), 64'd0);
    chk("t3_addr0", bus3.spl_addr, 64'h3100);
    tick();
    txn3 = 1'b1;
    tick();
    txn3 = 1'b0;
    tick();
    chk("t3_ready1", 64'(bus3.req_ready), 64'b010);
    tick();
    tick();
    txn3 = 1'b1;
    tick();
    txn3 = 1'b0;
    #1;
    chk("t3_done1", 64'(bus3.req_done), 64'b010);
    tick();
    chk("t3_idle", 64'(busy3), 64'd0);
    chk("t3_err", 64'(err3), 64'd0);

    // 2: all four valid continuously from rr_ptr=0
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    auto_clear = 1'b0;
    for (int i = 0; i < 4; i++) set_req4(i, 64'h100 * (i + 1), 16'(16 * (i + 1)));
    for (int g = 0; g < 5; g++) begin
      wait_ready4(8, oh);
      chk($sformatf("t2_grant_%0d", g), 64'(oh), 64'(exp_order[g]));
      tick();
      if (g == 4) bus4.req_valid = '0;
      tick();
      txn4 = 1'b1;
      tick();
      txn4 = 1'b0;
      tick();
    end
    auto_clear = 1'b1;

    // 4: zero-size request from requester 1 (rr_ptr now 1)
    set_req4(1, 64'h2000, 16'd0);
    #1;
    chk("t4_ready", 64'(bus4.req_ready), 64'b0010);
    tick();
    chk("t4_done", 64'(bus4.req_done), 64'b0010);
    chk("t4_no_strobe", 64'(bus4.spl_addr_valid), 64'd0);
    tick();
    chk("t4_idle", 64'(busy4), 64'd0);

    // 5: splitter busy for 5 cycles
    bus4.spl_idle = 1'b0;
    set_req4(0, 64'h4000, 16'd32);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t5_no_ready", 64'(bus4.req_ready), 64'd0);
      tick();
    end
    bus4.spl_idle = 1'b1;
    #1;
    chk("t5_ready", 64'(bus4.req_ready), 64'b0001);
    finish4();

    // 6: stray txn_done in IDLE, then reset during WAIT_DONE
    txn4 = 1'b1;
    tick();
    txn4 = 1'b0;
    #1;
    chk("t6_err_set", 64'(err4), 64'd1);
    tick();
    tick();
    chk("t6_err_sticky", 64'(err4), 64'd1);
    set_req4(3, 64'h5000, 16'd8);
    #1;
    chk("t6_ready3", 64'(bus4.req_ready), 64'b1000);
    tick();
    tick();
    chk("t6_busy_wait", 64'(busy4), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy4), 64'd0);
    chk("t6_rst_err", 64'(err4), 64'd0);
    chk("t6_rst_done", 64'(bus4.req_done), 64'd0);
    chk("t6_rst_addr", bus4.spl_addr, 64'd0);
    tick();
    chk("t6_no_late_done", 64'(bus4.req_done), 64'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
